// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// types_pkg : shared bus width, UART framing constants and TX state encoding
// Revision  : 1.0
// ============================================================================
package types_pkg;

  localparam int DATA_BUS        = 32;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state;

endpackage
`default_nettype wire

// File: rtl/a0_fifo.sv
`default_nettype none
// ============================================================================
// a0_fifo : synchronous circular-buffer FIFO of DATA_BUS-wide words
// Revision  : 1.0
// ============================================================================
module a0_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_BUS-1:0]       din,
  output logic [DATA_BUS-1:0]       dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int                c_ptr_w = $clog2(DEPTH);
  localparam int                c_lvl_w = c_ptr_w + 1;
  localparam logic [c_lvl_w-1:0] c_full  = c_lvl_w'(DEPTH);

  logic [DATA_BUS-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;

  logic w_wr_en;
  logic w_rd_en;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_wr_en = push && (!full || pop);
  assign w_rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + c_lvl_w'(1);
        2'b01:   r_level <= r_level - c_lvl_w'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == c_full);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/a0_uart_tx.sv
`default_nettype none
// ============================================================================
// a0_uart_tx : queues every change of a0 and sends it as four 8N1 UART bytes
// Revision  : 1.0
// ============================================================================
module a0_uart_tx
  import types_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_BUS-1:0]          a0,
  input  logic                         en,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow
);

  localparam int                 c_baud_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          c_last_bit  = 3'(UART_FRAME_BITS - 3);
  localparam logic [1:0]          c_last_byte = 2'(DATA_BUS / 8 - 1);

  uart_state             r_state;
  logic [DATA_BUS-1:0]   r_prev_a0;
  logic [DATA_BUS-1:0]   r_shift;
  logic [1:0]            r_byte_idx;
  logic [2:0]            r_bit_cnt;
  logic [c_baud_w-1:0]   r_baud;
  logic                  r_tx;
  logic                  r_overflow;

  logic                  w_push_req;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [DATA_BUS-1:0]   w_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;

  assign w_push_req = en && (a0 != r_prev_a0);
  assign w_pop      = (r_state == IDLE) && !w_empty;

  a0_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .din   (a0),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // prev_a0 tracks a0 even while capture is disabled, so re-enabling never replays a stale change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev_a0  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_prev_a0 <= a0;
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_tx       <= 1'b1;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_bit_cnt  <= '0;
      r_baud     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift    <= w_head;
            r_byte_idx <= '0;
            r_baud     <= '0;
            r_tx       <= 1'b0;
            r_state    <= START;
          end
        end
        START: begin
          if (r_baud == c_baud_last) begin
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        DATA: begin
          if (r_baud == c_baud_last) begin
            r_baud  <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == c_last_bit) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        STOP: begin
          if (r_baud == c_baud_last) begin
            r_baud <= '0;
            // After eight shifts the next byte already sits in the low bits.
            if (r_byte_idx != c_last_byte) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_tx       <= 1'b0;
              r_state    <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + c_baud_w'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != IDLE) || (w_level != '0);
  assign level    = w_level;
  assign overflow = r_overflow;

endmodule
`default_nettype wire
